// File: rtl/exc_pkg.sv
// Shared types and ExcCodes for the exception/interrupt arbiter.
package exc_pkg;

  localparam int unsigned EXC_W = 5;
  localparam int unsigned ID_W  = 3;

  localparam logic [EXC_W-1:0] EXC_INT = 5'd0;
  localparam logic [EXC_W-1:0] EXC_SYS = 5'd8;
  localparam logic [EXC_W-1:0] EXC_BP  = 5'd9;
  localparam logic [EXC_W-1:0] EXC_TR  = 5'd13;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  typedef enum logic [2:0] {EV_SYS, EV_BP, EV_TR, EV_ERET, EV_INT} ev_kind_e;

  // Event latched at arbitration and held until the window closes
  typedef struct packed {
    ev_kind_e         kind;
    logic [EXC_W-1:0] cause;
    logic [ID_W-1:0]  id;
  } evt_t;

endpackage

// File: rtl/irq_sync.sv
// Per-line 2-flop synchroniser followed by a single-cycle rising-edge detector.
module irq_sync #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1_q, s2_q, hist_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      hist_q <= '0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      hist_q <= s2_q;
    end
  end

  assign rise = s2_q & ~hist_q;

endmodule

// File: rtl/exc_arbiter.sv
// Picks one exception/eret/interrupt per window and drives CP0 with single-cycle pulses.
module exc_arbiter
  import exc_pkg::*;
#(
  parameter int unsigned N_IRQ = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             syscall_req,
  input  logic             break_req,
  input  logic             trap_req,
  input  logic             eret_req,
  input  logic             int_enable,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             ans_exception,
  output logic             exception,
  output logic             eret,
  output logic [EXC_W-1:0] cause,
  output logic [ID_W-1:0]  irq_id,
  output logic             stall,
  output logic             exc_dropped
);

  state_e           state_q, state_d;
  evt_t             evt_q, evt_d, win;
  logic [N_IRQ-1:0] pending_q, pending_d, rise, eligible, clr_mask;
  logic             irq_ok, any_event;
  logic             exception_d, eret_d, dropped_d;

  irq_sync #(.W(N_IRQ)) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .din   (irq),
    .rise  (rise)
  );

  assign eligible  = pending_q & irq_mask;
  assign irq_ok    = int_enable && (|eligible);
  assign any_event = syscall_req || break_req || trap_req || eret_req || irq_ok;
  assign clr_mask  = N_IRQ'(1) << evt_q.id;

  // Fixed-priority winner; the downward scan leaves the lowest eligible line
  always_comb begin
    win = '{kind: EV_INT, cause: EXC_INT, id: '0};
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) win.id = ID_W'(i);
    end
    if (syscall_req)    win = '{kind: EV_SYS,  cause: EXC_SYS, id: '0};
    else if (break_req) win = '{kind: EV_BP,   cause: EXC_BP,  id: '0};
    else if (trap_req)  win = '{kind: EV_TR,   cause: EXC_TR,  id: '0};
    else if (eret_req)  win = '{kind: EV_ERET, cause: EXC_INT, id: '0};
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_event) state_d = S_ISSUE;
      S_ISSUE: state_d = (evt_q.kind == EV_ERET) ? S_IDLE : S_WAIT;
      S_WAIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    evt_d       = evt_q;
    exception_d = 1'b0;
    eret_d      = 1'b0;
    dropped_d   = 1'b0;
    pending_d   = pending_q | rise;
    case (state_q)
      S_IDLE: begin
        if (any_event) begin
          evt_d       = win;
          exception_d = (win.kind != EV_ERET);
          eret_d      = (win.kind == EV_ERET);
        end
      end
      S_WAIT: begin
        if (evt_q.kind == EV_INT) begin
          if (ans_exception) pending_d = (pending_q & ~clr_mask) | rise;
        end else if (!ans_exception) begin
          dropped_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      evt_q       <= '0;
      pending_q   <= '0;
      exception   <= 1'b0;
      eret        <= 1'b0;
      exc_dropped <= 1'b0;
    end else begin
      evt_q       <= evt_d;
      pending_q   <= pending_d;
      exception   <= exception_d;
      eret        <= eret_d;
      exc_dropped <= dropped_d;
    end
  end

  assign cause  = evt_q.cause;
  assign irq_id = evt_q.id;
  // Combinational so the PC holds in the very cycle a request is seen
  assign stall  = ((state_q == S_IDLE) && any_event) || (state_q == S_ISSUE) || (state_q == S_WAIT);

endmodule

// File: tb/tb_exc_arbiter.sv
// Directed bench for exc_arbiter: expected CP0 events are queued, a negedge monitor checks them.
module tb_exc_arbiter;
  import exc_pkg::*;

  localparam int unsigned N = 6;
  localparam logic [1:0] T_EXC = 2'd0, T_ERET = 2'd1, T_DROP = 2'd2;

  typedef struct packed {
    logic [1:0] typ;
    logic [4:0] cause;
    logic [2:0] id;
  } exp_t;

  logic         clk, reset;
  logic         syscall_req, break_req, trap_req, eret_req, int_enable, ans_exception;
  logic [N-1:0] irq, irq_mask;
  logic         exception, eret, stall, exc_dropped;
  logic [4:0]   cause;
  logic [2:0]   irq_id;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  exc_arbiter #(.N_IRQ(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .syscall_req   (syscall_req),
    .break_req     (break_req),
    .trap_req      (trap_req),
    .eret_req      (eret_req),
    .int_enable    (int_enable),
    .irq           (irq),
    .irq_mask      (irq_mask),
    .ans_exception (ans_exception),
    .exception     (exception),
    .eret          (eret),
    .cause         (cause),
    .irq_id        (irq_id),
    .stall         (stall),
    .exc_dropped   (exc_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every CP0-facing pulse must match the next queued expectation
  always @(negedge clk) begin
    exp_t got, e;
    if (reset && (exception || eret || exc_dropped)) begin
      got.typ   = exception ? T_EXC : (eret ? T_ERET : T_DROP);
      got.cause = exception ? cause : 5'd0;
      got.id    = (exception && cause == EXC_INT) ? irq_id : 3'd0;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=%0h required=none", got);
      end else begin
        e = q.pop_front();
        chk("event", 32'(got), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; syscall_req = 0; break_req = 0; trap_req = 0; eret_req = 0;
    int_enable = 0; ans_exception = 0; irq = '0; irq_mask = '0;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_exception", 32'(exception), 0);
    chk("rst_outputs", {eret, exc_dropped, cause, irq_id}, 0);
    chk("rst_stall", 32'(stall), 0);
    cyc();
    reset = 1'b1;
    irq_mask = 6'h3F; int_enable = 1'b1;
    repeat (2) cyc();

    // syscall accepted, CP0 records it
    ans_exception = 1'b1;
    q.push_back('{T_EXC, EXC_SYS, 3'd0});
    syscall_req = 1'b1;
    @(negedge clk); chk("sys_stall_n", 32'(stall), 1); chk("sys_exc_n", 32'(exception), 0);
    cyc(); syscall_req = 1'b0;
    @(negedge clk); chk("sys_exc_n1", 32'(exception), 1); chk("sys_stall_n1", 32'(stall), 1);
    cyc();
    @(negedge clk); chk("sys_stall_n2", 32'(stall), 1); chk("sys_exc_n2", 32'(exception), 0);
    cyc();
    @(negedge clk); chk("sys_stall_n3", 32'(stall), 0); chk("sys_drop_n3", 32'(exc_dropped), 0);
    cyc();

    // all three instruction requests together, then break alone
    q.push_back('{T_EXC, EXC_SYS, 3'd0});
    syscall_req = 1'b1; break_req = 1'b1; trap_req = 1'b1;
    cyc(); syscall_req = 0; break_req = 0; trap_req = 0;
    repeat (3) cyc();
    q.push_back('{T_EXC, EXC_BP, 3'd0});
    break_req = 1'b1;
    cyc(); break_req = 1'b0;
    repeat (3) cyc();

    // single interrupt on line 3
    q.push_back('{T_EXC, EXC_INT, 3'd3});
    irq = 6'b001000;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 2) chk("irq3_not_yet", 32'(dut.pending_q), 0);
      if (c == 3) begin chk("irq3_pending", 32'(dut.pending_q), 32'h08); chk("irq3_stall", 32'(stall), 1); end
      if (c == 4) begin chk("irq3_exc", 32'(exception), 1); chk("irq3_id", 32'(irq_id), 3); end
      if (c == 6) begin chk("irq3_cleared", 32'(dut.pending_q), 0); chk("irq3_stall_end", 32'(stall), 0); end
      cyc();
    end
    irq = '0;
    repeat (4) cyc();

    // lines 1 and 4 together: lowest index first, next three cycles later
    q.push_back('{T_EXC, EXC_INT, 3'd1});
    q.push_back('{T_EXC, EXC_INT, 3'd4});
    irq = 6'b010010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 4) chk("two_first_id", 32'(irq_id), 1);
      if (c == 6) chk("two_left_pending", 32'(dut.pending_q), 32'h10);
      if (c == 7) begin chk("two_second_exc", 32'(exception), 1); chk("two_second_id", 32'(irq_id), 4); end
      if (c == 9) chk("two_cleared", 32'(dut.pending_q), 0);
      cyc();
    end
    irq = '0;
    repeat (3) cyc();

    // eret collides with an eligible interrupt on line 0
    int_enable = 1'b0;
    irq = 6'b000001;
    repeat (4) cyc();
    @(negedge clk); chk("irq0_disabled_stall", 32'(stall), 0);
    cyc();
    irq = '0;
    q.push_back('{T_ERET, 5'd0, 3'd0});
    q.push_back('{T_EXC, EXC_INT, 3'd0});
    int_enable = 1'b1; eret_req = 1'b1;
    cyc(); eret_req = 1'b0;
    @(negedge clk); chk("eret_pulse", 32'(eret), 1); chk("eret_no_exc", 32'(exception), 0);
    cyc();
    @(negedge clk); chk("eret_irq_stall", 32'(stall), 1);
    cyc();
    @(negedge clk); chk("eret_then_irq", 32'(exception), 1);
    repeat (2) cyc();
    @(negedge clk); chk("irq0_cleared", 32'(dut.pending_q), 0);
    cyc();

    // trap refused by CP0
    ans_exception = 1'b0;
    q.push_back('{T_EXC, EXC_TR, 3'd0});
    q.push_back('{T_DROP, 5'd0, 3'd0});
    trap_req = 1'b1;
    cyc(); trap_req = 1'b0;
    cyc();
    @(negedge clk); chk("trap_drop_n2", 32'(exc_dropped), 0);
    cyc();
    @(negedge clk); chk("trap_drop_n3", 32'(exc_dropped), 1); chk("trap_stall_n3", 32'(stall), 0);
    cyc();

    // interrupt refused once, then re-issued and taken
    q.push_back('{T_EXC, EXC_INT, 3'd2});
    q.push_back('{T_EXC, EXC_INT, 3'd2});
    irq = 6'b000100;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 6) begin chk("refused_pending", 32'(dut.pending_q), 32'h04); chk("refused_stall", 32'(stall), 1); end
      if (c == 7) chk("reissue_exc", 32'(exception), 1);
      if (c == 9) chk("reissue_cleared", 32'(dut.pending_q), 0);
      cyc();
      if (c == 5) ans_exception = 1'b1;
    end
    irq = '0;
    repeat (3) cyc();

    // masked line stays pending without an event until unmasked
    irq_mask = 6'h1F;
    irq = 6'b100000;
    repeat (6) cyc();
    @(negedge clk); chk("masked_pending", 32'(dut.pending_q), 32'h20); chk("masked_stall", 32'(stall), 0);
    cyc();
    irq = '0;
    q.push_back('{T_EXC, EXC_INT, 3'd5});
    irq_mask = 6'h3F;
    repeat (5) cyc();
    @(negedge clk); chk("unmasked_cleared", 32'(dut.pending_q), 0);
    cyc();

    // reset during WAIT aborts the event and clears pending state
    irq_mask = 6'h1F;
    irq = 6'b100000;
    repeat (5) cyc();
    irq = '0;
    repeat (3) cyc();
    q.push_back('{T_EXC, EXC_SYS, 3'd0});
    syscall_req = 1'b1;
    cyc(); syscall_req = 1'b0;
    @(negedge clk); chk("rstw_exc", 32'(exception), 1);
    cyc();
    reset = 1'b0;
    @(negedge clk); chk("rstw_wait_stall", 32'(stall), 1);
    cyc();
    @(negedge clk);
    chk("rstw_outputs", {exception, eret, exc_dropped, cause, irq_id}, 0);
    chk("rstw_pending", 32'(dut.pending_q), 0);
    chk("rstw_state", 32'(dut.state_q), 32'(S_IDLE));
    chk("rstw_stall", 32'(stall), 0);
    cyc();
    reset = 1'b1;
    irq_mask = 6'h3F;
    repeat (5) cyc();

    chk("queue_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
